game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
- Match sequencer for the pong game. Sits beside the ball and the two paddle instances at the top level.
- Gates ball motion and paddle motion, and launches serves with a start pulse.
- Counts misses as points, paces serve and point pauses in video frames, and declares a winner.
- Runs on the system clock; frame pacing comes from the VGA vsync.

Parameters:
- WIN_SCORE, 7: points needed to win; scores never exceed this value.
- SERVE_FRAMES, 60: frames the ball is held at centre before launch.
- POINT_FRAMES, 90: frames of freeze after a point is scored.
- SCORE_W, $clog2(WIN_SCORE+1): width of each score output (derived).

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- vsync  in  1  raw VGA vsync, active-low pulse. Its falling edge is the frame tick.
- start_btn  in  1  active-high, already debounced; acted on at its rising edge.
- miss_left  in  1  ball left the field past the left paddle; level or pulse, rising-edge detected.
- miss_right  in  1  same, for the right side.
- pause_btn  in  1  active-high; port exists only with PAUSE_EN.
- ball_start  out  1  one-cycle pulse: ball recentres and loads its direction.
- ball_run  out  1  ball motion enable.
- serve_dir  out  1  0 = serve toward left player, 1 = toward right player.
- paddle_en  out  1  paddle motion enable.
- score1  out  SCORE_W  left player score.
- score2  out  SCORE_W  right player score.
- game_over  out  1  high while in GAME_OVER.
- winner  out  1  0 = left won, 1 = right won; valid while game_over is high.
- state  out  3  encoded current state, for debug.

Behaviour:
- Reset values:
  - State IDLE; all outputs 0.
  - Frame counter 0.
  - Edge-detector history: vsync_q=1, all others 0. No spurious edge after reset.
- Edge detection:
  - Every input edge is detected against a one-cycle registered copy of that input.
  - frame_tick = vsync_q & ~vsync.
- All outputs are registered. An input edge sampled in cycle N is reflected on the outputs in cycle N+1.
- IDLE:
  - ball_run=0, paddle_en=0.
  - start edge -> SERVE: scores cleared, counter loaded with SERVE_FRAMES, ball_start=1 for that single cycle.
- SERVE:
  - ball_run=0, paddle_en=1.
  - Counter decrements on each frame_tick.
  - frame_tick while counter==1 -> PLAY. SERVE therefore lasts exactly SERVE_FRAMES ticks.
- PLAY:
  - ball_run=1, paddle_en=1.
  - miss_left edge: score2+1, serve_dir<=0.
  - miss_right edge: score1+1, serve_dir<=1.
  - Both edges in the same cycle: no score change, serve_dir unchanged, point replayed.
  - Any miss -> POINT with counter loaded with POINT_FRAMES. Exception: if the updated score equals WIN_SCORE -> GAME_OVER, with winner = 1 if score2 won, else 0.
- POINT:
  - ball_run=0, paddle_en=1.
  - Counts down like SERVE. On expiry -> SERVE with counter = SERVE_FRAMES and a ball_start pulse.
- GAME_OVER:
  - game_over=1, ball_run=0, paddle_en=0. Scores and winner hold.
  - start edge -> SERVE, identical to the IDLE start (scores cleared, winner cleared, serve_dir kept).
- Ignored events:
  - Miss edges outside PLAY.
  - Start edges in SERVE, PLAY and POINT.
- Boundary rules:
  - Scores saturate at WIN_SCORE by construction.
  - A frame tick and a state change in the same cycle: the transition wins, and the counter is loaded rather than decremented.
  - Reset asserted at any time overrides everything on that edge.
- ball_start is never high for two consecutive cycles.

Optional Feature:
- Macro: GAME_CTRL_PAUSE_EN.
- Defined:
  - pause_btn port present; PAUSED state added.
  - pause edge in PLAY -> PAUSED: ball_run=0, paddle_en=0, frame counter frozen, miss edges ignored.
  - Next pause edge -> PLAY.
  - Pause edges in other states are ignored.
  - A pause edge coincident with a miss edge: the miss wins.
- Undefined: no pause_btn port, no PAUSED state; PAUSED encoding unused.

Decomposition:
- pong_pkg holds:
  - game_state_t enum: IDLE, SERVE, PLAY, POINT, GAME_OVER, PAUSED.
  - Default constants for WIN_SCORE, SERVE_FRAMES and POINT_FRAMES.
- One sub-module, edge_detect:
  - Parameterised on rising/falling edge and on reset value.
  - Registered history bit, combinational pulse output.
  - Instanced for vsync, start_btn, miss_left, miss_right and pause_btn.

Test Plan:
Bench parameters for all scenarios: WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=3.
- Reset, then start pulse -> next cycle: state=SERVE, ball_start=1 for exactly 1 cycle, paddle_en=1, ball_run=0. After 2 vsync falling edges, ball_run=1.
- In PLAY, pulse miss_right -> score1=1, serve_dir=1, ball_run=0. After 3 ticks: SERVE with ball_start pulse. After 2 more ticks: PLAY.
- miss_left and miss_right rising in the same cycle -> scores unchanged, POINT entered, serve_dir unchanged.
- Three miss_left points -> score2=3, game_over=1, winner=1. Further misses leave score2=3. A start edge clears scores and reaches SERVE.
- Miss pulses in SERVE and POINT, and start pulses in PLAY -> no effect on scores or state.
- Reset asserted mid-POINT with score1=2 -> next cycle: IDLE, scores 0, all outputs 0. With GAME_CTRL_PAUSE_EN defined: pause in PLAY freezes ball_run and paddle_en at 0, a miss while paused is ignored, and a second pause edge returns to PLAY.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding and default match parameters for the pong game
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4,
        PAUSED    = 3'd5
    } game_state_t;

    localparam int WIN_SCORE_DEF    = 7;
    localparam int SERVE_FRAMES_DEF = 60;
    localparam int POINT_FRAMES_DEF = 90;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// game_ctrl_if: match-sequencer signal bundle; pause_btn exists only with GAME_CTRL_PAUSE_EN
interface game_ctrl_if #(
    parameter int SCORE_W = 3
);

    logic               vsync;
    logic               start_btn;
    logic               miss_left;
    logic               miss_right;
`ifdef GAME_CTRL_PAUSE_EN
    logic               pause_btn;
`endif
    logic               ball_start;
    logic               ball_run;
    logic               serve_dir;
    logic               paddle_en;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic               game_over;
    logic               winner;
    logic [2:0]         state;

    modport master (
`ifdef GAME_CTRL_PAUSE_EN
        input  pause_btn,
`endif
        input  vsync, start_btn, miss_left, miss_right,
        output ball_start, ball_run, serve_dir, paddle_en,
        output score1, score2, game_over, winner, state
    );

    modport slave (
`ifdef GAME_CTRL_PAUSE_EN
        output pause_btn,
`endif
        output vsync, start_btn, miss_left, miss_right,
        input  ball_start, ball_run, serve_dir, paddle_en,
        input  score1, score2, game_over, winner, state
    );

endinterface

// File: rtl/edge_detect.sv
// edge_detect: one-cycle edge pulse against a registered copy of the input
module edge_detect #(
    parameter bit RISE = 1'b1,
    parameter bit INIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic pulse
);

    logic q;

    // history bit; INIT chosen so no edge is seen right after reset
    always_ff @(posedge clk) begin
        q <= reset ? INIT : d;
    end

    assign pulse = RISE ? (d & ~q) : (q & ~d);

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: pong match sequencer (serve, play, point pause, game over); GAME_CTRL_PAUSE_EN adds PAUSED
module game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int POINT_FRAMES = POINT_FRAMES_DEF,
    parameter int SCORE_W      = $clog2(WIN_SCORE + 1)
) (
    input logic         clk,
    input logic         reset,
    game_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(max2(SERVE_FRAMES, POINT_FRAMES) + 1);

    localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] ONE  = SCORE_W'(1);
    localparam logic [CNT_W-1:0]   SRV  = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   PNT  = CNT_W'(POINT_FRAMES);
    localparam logic [CNT_W-1:0]   LAST = CNT_W'(1);

    logic tick, start_e, ml_e, mr_e;

    game_state_t        state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [SCORE_W-1:0] s1_q, s1_n, s2_q, s2_n;
    logic               dir_q, dir_n, win_q, win_n, bs_q, bs_n;
    logic               run_q, pad_q, go_q;

    edge_detect #(.RISE(1'b0), .INIT(1'b1)) u_vsync (.clk(clk), .reset(reset), .d(bus.vsync),      .pulse(tick));
    edge_detect #(.RISE(1'b1), .INIT(1'b0)) u_start (.clk(clk), .reset(reset), .d(bus.start_btn),  .pulse(start_e));
    edge_detect #(.RISE(1'b1), .INIT(1'b0)) u_ml    (.clk(clk), .reset(reset), .d(bus.miss_left),  .pulse(ml_e));
    edge_detect #(.RISE(1'b1), .INIT(1'b0)) u_mr    (.clk(clk), .reset(reset), .d(bus.miss_right), .pulse(mr_e));

`ifdef GAME_CTRL_PAUSE_EN
    logic pause_e;
    edge_detect #(.RISE(1'b1), .INIT(1'b0)) u_pause (.clk(clk), .reset(reset), .d(bus.pause_btn), .pulse(pause_e));
`endif

    // next state and next registered outputs; transitions load the counter instead of decrementing
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        s1_n    = s1_q;
        s2_n    = s2_q;
        dir_n   = dir_q;
        win_n   = win_q;
        bs_n    = 1'b0;
        case (state_q)
            IDLE, GAME_OVER: begin
                if (start_e) begin
                    state_n = SERVE;
                    cnt_n   = SRV;
                    s1_n    = '0;
                    s2_n    = '0;
                    win_n   = 1'b0;
                    bs_n    = 1'b1;
                end
            end
            SERVE: begin
                if (tick) begin
                    state_n = (cnt_q == LAST) ? PLAY : SERVE;
                    cnt_n   = (cnt_q == LAST) ? '0 : cnt_q - LAST;
                end
            end
            PLAY: begin
                if (ml_e && mr_e) begin
                    state_n = POINT;
                    cnt_n   = PNT;
                end else if (ml_e) begin
                    s2_n    = s2_q + ONE;
                    dir_n   = 1'b0;
                    state_n = (s2_n == WIN) ? GAME_OVER : POINT;
                    win_n   = (s2_n == WIN);
                    cnt_n   = (s2_n == WIN) ? '0 : PNT;
                end else if (mr_e) begin
                    s1_n    = s1_q + ONE;
                    dir_n   = 1'b1;
                    state_n = (s1_n == WIN) ? GAME_OVER : POINT;
                    win_n   = 1'b0;
                    cnt_n   = (s1_n == WIN) ? '0 : PNT;
                end
`ifdef GAME_CTRL_PAUSE_EN
                else if (pause_e) begin
                    state_n = PAUSED;
                end
`endif
            end
            POINT: begin
                if (tick) begin
                    state_n = (cnt_q == LAST) ? SERVE : POINT;
                    cnt_n   = (cnt_q == LAST) ? SRV : cnt_q - LAST;
                    bs_n    = (cnt_q == LAST);
                end
            end
`ifdef GAME_CTRL_PAUSE_EN
            PAUSED: begin
                if (pause_e) begin
                    state_n = PLAY;
                end
            end
`endif
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // state, counter and all outputs registered; enables derive from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            dir_q   <= 1'b0;
            win_q   <= 1'b0;
            bs_q    <= 1'b0;
            run_q   <= 1'b0;
            pad_q   <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            s1_q    <= s1_n;
            s2_q    <= s2_n;
            dir_q   <= dir_n;
            win_q   <= win_n;
            bs_q    <= bs_n;
            run_q   <= (state_n == PLAY);
            pad_q   <= (state_n == SERVE) || (state_n == PLAY) || (state_n == POINT);
            go_q    <= (state_n == GAME_OVER);
        end
    end

    assign bus.state      = state_q;
    assign bus.ball_start = bs_q;
    assign bus.ball_run   = run_q;
    assign bus.paddle_en  = pad_q;
    assign bus.serve_dir  = dir_q;
    assign bus.score1     = s1_q;
    assign bus.score2     = s2_q;
    assign bus.game_over  = go_q;
    assign bus.winner     = win_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed and random stimulus checked every cycle against a rule-level match model
module tb_game_ctrl;
    import pong_pkg::*;

    localparam int WS = 3;
    localparam int SF = 2;
    localparam int PF = 3;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   rand_v = 1'b0;
    int   vcnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    game_state_t m_state;
    int          m_left;
    int          m_s[2];
    int          m_dir, m_win, m_bs;
    logic        p_v, p_s, p_l, p_r, p_p;

    // free-running system clock
    always #5 clk = ~clk;

    game_ctrl_if #(.SCORE_W(SW)) bus ();

    game_ctrl #(
        .WIN_SCORE(WS),
        .SERVE_FRAMES(SF),
        .POINT_FRAMES(PF),
        .SCORE_W(SW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_step();
        logic pb, tick, se, le, re, pe;
        int   w;
`ifdef GAME_CTRL_PAUSE_EN
        pb = bus.pause_btn;
`else
        pb = 1'b0;
`endif
        if (reset) begin
            m_state = IDLE;
            m_left  = 0;
            m_s[0]  = 0;
            m_s[1]  = 0;
            m_dir   = 0;
            m_win   = 0;
            m_bs    = 0;
            p_v = 1'b1; p_s = 1'b0; p_l = 1'b0; p_r = 1'b0; p_p = 1'b0;
            return;
        end
        tick = p_v & ~bus.vsync;
        se   = bus.start_btn & ~p_s;
        le   = bus.miss_left & ~p_l;
        re   = bus.miss_right & ~p_r;
        pe   = pb & ~p_p;
        m_bs = 0;
        case (m_state)
            IDLE, GAME_OVER: if (se) begin
                m_state = SERVE;
                m_left  = SF;
                m_s[0]  = 0;
                m_s[1]  = 0;
                m_win   = 0;
                m_bs    = 1;
            end
            SERVE: if (tick) begin
                m_left--;
                if (m_left == 0) m_state = PLAY;
            end
            PLAY: begin
                if (le && re) begin
                    m_state = POINT;
                    m_left  = PF;
                end else if (le || re) begin
                    w = le ? 1 : 0;
                    m_s[w]++;
                    m_dir = le ? 0 : 1;
                    if (m_s[w] == WS) begin
                        m_state = GAME_OVER;
                        m_win   = w;
                    end else begin
                        m_state = POINT;
                        m_left  = PF;
                    end
                end else if (pe) begin
                    m_state = PAUSED;
                end
            end
            POINT: if (tick) begin
                m_left--;
                if (m_left == 0) begin
                    m_state = SERVE;
                    m_left  = SF;
                    m_bs    = 1;
                end
            end
            PAUSED: if (pe) m_state = PLAY;
            default: ;
        endcase
        p_v = bus.vsync; p_s = bus.start_btn; p_l = bus.miss_left; p_r = bus.miss_right; p_p = pb;
    endtask

    task automatic compare_all();
        check("state",      bus.state,      m_state);
        check("ball_start", bus.ball_start, m_bs);
        check("ball_run",   bus.ball_run,   m_state == PLAY);
        check("paddle_en",  bus.paddle_en,  m_state == SERVE || m_state == PLAY || m_state == POINT);
        check("serve_dir",  bus.serve_dir,  m_dir);
        check("score1",     bus.score1,     m_s[0]);
        check("score2",     bus.score2,     m_s[1]);
        check("game_over",  bus.game_over,  m_state == GAME_OVER);
        check("winner",     bus.winner,     m_win);
    endtask

    task automatic cyc(input logic rst, input logic st, input logic ml, input logic mr, input logic pb);
        reset          = rst;
        bus.start_btn  = st;
        bus.miss_left  = ml;
        bus.miss_right = mr;
`ifdef GAME_CTRL_PAUSE_EN
        bus.pause_btn  = pb;
`else
        if (pb) ;
`endif
        bus.vsync = rand_v ? ($urandom % 3 != 0) : ((vcnt % 5) != 4);
        vcnt++;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // directed match scenarios followed by a long random run
    initial begin
        bus.vsync      = 1'b1;
        bus.start_btn  = 1'b0;
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
`ifdef GAME_CTRL_PAUSE_EN
        bus.pause_btn  = 1'b0;
`endif
        @(negedge clk);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_state", bus.state, IDLE);
        check("reset_paddle", bus.paddle_en, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("start_serve", bus.state, SERVE);
        check("start_pulse", bus.ball_start, 1);
        check("start_paddle", bus.paddle_en, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("start_pulse_once", bus.ball_start, 0);
        idle(15);
        check("serve_to_play", bus.ball_run, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("miss_r_score1", bus.score1, 1);
        check("miss_r_dir", bus.serve_dir, 1);
        check("miss_r_run", bus.ball_run, 0);
        idle(35);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("both_state", bus.state, POINT);
        check("both_score1", bus.score1, 1);
        check("both_dir", bus.serve_dir, 1);
        idle(35);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("start_in_play", bus.state, PLAY);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (i < 2) begin
                cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                idle(35);
            end
        end
        check("go_flag", bus.game_over, 1);
        check("go_winner", bus.winner, 1);
        check("go_score2", bus.score2, WS);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("go_score2_hold", bus.score2, WS);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("restart_state", bus.state, SERVE);
        check("restart_score2", bus.score2, 0);
        idle(15);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(35);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        check("mid_point_score1", bus.score1, 2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_reset_state", bus.state, IDLE);
        check("mid_reset_score1", bus.score1, 0);
`ifdef GAME_CTRL_PAUSE_EN
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(15);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("pause_run", bus.ball_run, 0);
        check("pause_paddle", bus.paddle_en, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pause_miss", bus.state, PAUSED);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("unpause", bus.state, PLAY);
`endif
        rand_v = 1'b1;
        repeat (4000) begin
            cyc(1'($urandom % 400 == 0), 1'($urandom % 30 == 0), 1'($urandom % 8 == 0),
                1'($urandom % 8 == 0), 1'($urandom % 25 == 0));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
